// File: rtl/tank_plant.sv
// Water-tank emulator: integrates valve commands into a saturating level and
// drives registered float-switch lines, with fault injection for sensor errors.
module tank_plant #(
  parameter int TICK_DIV   = 1000,
  parameter int LEVEL_W    = 8,
  parameter int LVL_MAX    = 255,
  parameter int INIT_LEVEL = 0,
  parameter int FILL_RATE  = 4,
  parameter int DRIP_RATE  = 1,
  parameter int SPRAY_RATE = 3,
  parameter int LVL_L      = 20,
  parameter int LVL_M      = 100,
  parameter int LVL_H      = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Ve,
  input  logic               Vs,
  input  logic               Bs,
  input  logic [1:0]         fault_sel,
  input  logic               ovf_clr,
  output logic               H,
  output logic               M,
  output logic               L,
  output logic [LEVEL_W-1:0] level,
  output logic               tick,
  output logic               overflow,
  output logic               dry
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SUM_W = LEVEL_W + 3;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_L0   = 2'b01;
  localparam logic [1:0] FAULT_H1   = 2'b10;
  localparam logic [1:0] FAULT_M0   = 2'b11;

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [LEVEL_W-1:0] INIT_LVL  = LEVEL_W'(INIT_LEVEL);
  localparam logic [LEVEL_W-1:0] TH_L      = LEVEL_W'(LVL_L);
  localparam logic [LEVEL_W-1:0] TH_M      = LEVEL_W'(LVL_M);
  localparam logic [LEVEL_W-1:0] TH_H      = LEVEL_W'(LVL_H);
  localparam logic [LEVEL_W-1:0] MAX_LVL   = LEVEL_W'(LVL_MAX);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               dry_q, dry_d;
  logic               h_q, m_q, l_q;
  logic               h_d, m_d, l_d;

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] fill_s, drip_s, spray_s, max_s;
  logic                    set_ovf, set_dry;

  // Prescaler; tick is high for the cycle after the count hits its last value.
  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_q == CNT_LAST);
  end

  always_comb begin
    fill_s  = Ve ? SUM_W'(FILL_RATE)  : '0;
    drip_s  = Vs ? SUM_W'(DRIP_RATE)  : '0;
    spray_s = Bs ? SUM_W'(SPRAY_RATE) : '0;
    max_s   = SUM_W'(LVL_MAX);
    sum     = $signed({3'b000, level_q}) + fill_s - drip_s - spray_s;

    level_d = level_q;
    set_ovf = 1'b0;
    set_dry = 1'b0;
    if (tick_q) begin
      if (sum > max_s) begin
        level_d = MAX_LVL;
        set_ovf = 1'b1;
      end else if (sum[SUM_W-1]) begin
        level_d = '0;
        set_dry = 1'b1;
      end else begin
        level_d = sum[LEVEL_W-1:0];
      end
    end

    // A set on the same edge as a clear must win.
    ovf_d = set_ovf | (ovf_q & ~ovf_clr);
    dry_d = set_dry | (dry_q & ~ovf_clr);
  end

  always_comb begin
    l_d = (level_q >= TH_L);
    m_d = (level_q >= TH_M);
    h_d = (level_q >= TH_H);
    case (fault_sel)
      FAULT_L0:   l_d = 1'b0;
      FAULT_H1:   h_d = 1'b1;
      FAULT_M0:   m_d = 1'b0;
      FAULT_NONE: ;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      level_q <= INIT_LVL;
      ovf_q   <= 1'b0;
      dry_q   <= 1'b0;
      l_q     <= (INIT_LVL >= TH_L);
      m_q     <= (INIT_LVL >= TH_M);
      h_q     <= (INIT_LVL >= TH_H);
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      dry_q   <= dry_d;
      l_q     <= l_d;
      m_q     <= m_d;
      h_q     <= h_d;
    end
  end

  assign level    = level_q;
  assign tick     = tick_q;
  assign overflow = ovf_q;
  assign dry      = dry_q;
  assign H        = h_q;
  assign M        = m_q;
  assign L        = l_q;

endmodule
